// File: rtl/mips_ctrl_pkg.sv
// mips_ctrl_pkg: FSM states, opcode/funct constants, aluop and alucontrol codes for the multicycle controller
package mips_ctrl_pkg;
  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADR  = 4'd2,
    S_MEMRD   = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_EXECUTE = 4'd6,
    S_ALUWB   = 4'd7,
    S_BRANCH  = 4'd8,
    S_IMMEXEC = 4'd9,
    S_IMMWB   = 4'd10,
    S_JUMP    = 4'd11
  } state_t;
  localparam logic [5:0] OP_RTYPE = 6'h00, OP_J = 6'h02, OP_BEQ = 6'h04, OP_BNE = 6'h05;
  localparam logic [5:0] OP_ADDI = 6'h08, OP_ANDI = 6'h0C, OP_ORI = 6'h0D, OP_LW = 6'h23, OP_SW = 6'h2B;
  localparam logic [5:0] FN_ADD = 6'h20, FN_SUB = 6'h22, FN_AND = 6'h24, FN_OR = 6'h25, FN_SLT = 6'h2A;
  localparam logic [1:0] AOP_ADD = 2'b00, AOP_SUB = 2'b01, AOP_FUNCT = 2'b10, AOP_IMM = 2'b11;
  localparam logic [2:0] ALU_AND = 3'b000, ALU_OR = 3'b001, ALU_ADD = 3'b010, ALU_SUB = 3'b110, ALU_SLT = 3'b111;
endpackage

// File: rtl/multicycle_controller_if.sv
// multicycle_controller_if: IR fields, ALU flag and memory handshake in; datapath enables and muxes out
interface multicycle_controller_if #(
  parameter int OP_W = 6,
  parameter int FUNCT_W = 6,
  parameter int ALUCTRL_W = 3
);
  logic [OP_W-1:0] op;
  logic [FUNCT_W-1:0] funct;
  logic zero, mem_ready;
  logic pcen, memwrite, irwrite, regwrite, alusrca, iord, memtoreg, regdst, zeroext, illegal;
  logic [1:0] alusrcb, pcsrc;
  logic [ALUCTRL_W-1:0] alucontrol;
  modport master (
    input op, funct, zero, mem_ready,
    output pcen, memwrite, irwrite, regwrite, alusrca, alusrcb, pcsrc, iord, memtoreg, regdst,
           zeroext, alucontrol, illegal
  );
  modport slave (
    output op, funct, zero, mem_ready,
    input pcen, memwrite, irwrite, regwrite, alusrca, alusrcb, pcsrc, iord, memtoreg, regdst,
          zeroext, alucontrol, illegal
  );
endinterface

// File: rtl/mc_aludec.sv
// mc_aludec: maps aluop plus funct (R-type) or opcode (immediate logic) onto the ALU control code
module mc_aludec
  import mips_ctrl_pkg::*;
#(
  parameter int OP_W = 6,
  parameter int FUNCT_W = 6,
  parameter int ALUCTRL_W = 3
) (
  input  logic [1:0]           aluop,
  input  logic [FUNCT_W-1:0]   funct,
  input  logic [OP_W-1:0]      op,
  output logic [ALUCTRL_W-1:0] alucontrol
);
  logic [2:0] ctl, fctl, ictl;
  always_comb begin
    fctl = funct == FUNCT_W'(FN_SUB) ? ALU_SUB :
           funct == FUNCT_W'(FN_AND) ? ALU_AND :
           funct == FUNCT_W'(FN_OR)  ? ALU_OR  :
           funct == FUNCT_W'(FN_SLT) ? ALU_SLT : ALU_ADD;
    ictl = op == OP_W'(OP_ANDI) ? ALU_AND : op == OP_W'(OP_ORI) ? ALU_OR : ALU_ADD;
    ctl  = aluop == AOP_SUB ? ALU_SUB : aluop == AOP_FUNCT ? fctl : aluop == AOP_IMM ? ictl : ALU_ADD;
  end
  assign alucontrol = ALUCTRL_W'(ctl);
endmodule

// File: rtl/multicycle_controller.sv
// multicycle_controller: Moore FSM control unit for the multicycle MIPS datapath.
// Optional MC_MEM_WAIT_EN stalls FETCH/MEMRD/MEMWR until mem_ready.
module multicycle_controller
  import mips_ctrl_pkg::*;
#(
  parameter int OP_W = 6,
  parameter int FUNCT_W = 6,
  parameter int ALUCTRL_W = 3
) (
  input logic clk,
  input logic reset,
  multicycle_controller_if.master bus
);
  state_t state, state_nx;
  logic rdy, pcwrite, branch, bne;
  logic is_lw, is_sw, is_r, is_br, is_logic, is_imm, is_j, is_legal;
  logic [1:0] aluop;
  logic [ALUCTRL_W-1:0] alucontrol;
`ifdef MC_MEM_WAIT_EN
  assign rdy = bus.mem_ready;
`else
  logic unused_mem_ready;
  assign unused_mem_ready = bus.mem_ready;
  assign rdy = 1'b1;
`endif
  assign is_lw    = bus.op == OP_W'(OP_LW);
  assign is_sw    = bus.op == OP_W'(OP_SW);
  assign is_r     = bus.op == OP_W'(OP_RTYPE);
  assign is_br    = bus.op == OP_W'(OP_BEQ) || bus.op == OP_W'(OP_BNE);
  assign is_logic = bus.op == OP_W'(OP_ANDI) || bus.op == OP_W'(OP_ORI);
  assign is_imm   = bus.op == OP_W'(OP_ADDI) || is_logic;
  assign is_j     = bus.op == OP_W'(OP_J);
  assign is_legal = is_lw || is_sw || is_r || is_br || is_imm || is_j;
  always_ff @(posedge clk or negedge reset)
    if (!reset) state <= S_FETCH;
    else state <= state_nx;
  always_comb begin
    state_nx = S_FETCH;
    case (state)
      S_FETCH:   state_nx = rdy ? S_DECODE : S_FETCH;
      S_DECODE:  state_nx = is_lw || is_sw ? S_MEMADR : is_r ? S_EXECUTE : is_br ? S_BRANCH :
                            is_imm ? S_IMMEXEC : is_j ? S_JUMP : S_FETCH;
      S_MEMADR:  state_nx = is_lw ? S_MEMRD : S_MEMWR;
      S_MEMRD:   state_nx = rdy ? S_MEMWB : S_MEMRD;
      S_MEMWR:   state_nx = rdy ? S_FETCH : S_MEMWR;
      S_EXECUTE: state_nx = S_ALUWB;
      S_IMMEXEC: state_nx = S_IMMWB;
      default:   state_nx = S_FETCH;
    endcase
  end
  // Everything is held at zero while reset is low, so a mid-access abort never issues a write.
  always_comb begin
    pcwrite      = 1'b0;
    branch       = 1'b0;
    bne          = 1'b0;
    aluop        = AOP_ADD;
    bus.irwrite  = 1'b0;
    bus.memwrite = 1'b0;
    bus.regwrite = 1'b0;
    bus.alusrca  = 1'b0;
    bus.alusrcb  = 2'b00;
    bus.pcsrc    = 2'b00;
    bus.iord     = 1'b0;
    bus.memtoreg = 1'b0;
    bus.regdst   = 1'b0;
    bus.zeroext  = 1'b0;
    bus.illegal  = 1'b0;
    if (reset)
      case (state)
        S_FETCH:   begin bus.irwrite = rdy; pcwrite = rdy; bus.alusrcb = 2'b01; end
        S_DECODE:  begin bus.alusrcb = 2'b11; bus.illegal = !is_legal; end
        S_MEMADR:  begin bus.alusrca = 1'b1; bus.alusrcb = 2'b10; end
        S_MEMRD:   bus.iord = 1'b1;
        S_MEMWB:   begin bus.memtoreg = 1'b1; bus.regwrite = 1'b1; end
        S_MEMWR:   begin bus.iord = 1'b1; bus.memwrite = rdy; end
        S_EXECUTE: begin bus.alusrca = 1'b1; aluop = AOP_FUNCT; end
        S_ALUWB:   begin bus.regdst = 1'b1; bus.regwrite = 1'b1; end
        S_BRANCH:  begin
          bus.alusrca = 1'b1;
          aluop       = AOP_SUB;
          bus.pcsrc   = 2'b01;
          branch      = 1'b1;
          bne         = bus.op == OP_W'(OP_BNE);
        end
        S_IMMEXEC: begin
          bus.alusrca = 1'b1;
          bus.alusrcb = 2'b10;
          bus.zeroext = is_logic;
          aluop       = is_logic ? AOP_IMM : AOP_ADD;
        end
        S_IMMWB:   bus.regwrite = 1'b1;
        S_JUMP:    begin bus.pcsrc = 2'b10; pcwrite = 1'b1; end
        default:   ;
      endcase
    bus.pcen = pcwrite | (branch & (bus.zero ^ bne));
  end
  mc_aludec #(.OP_W(OP_W), .FUNCT_W(FUNCT_W), .ALUCTRL_W(ALUCTRL_W)) u_aludec (
    .aluop      (aluop),
    .funct      (bus.funct),
    .op         (bus.op),
    .alucontrol (alucontrol)
  );
  assign bus.alucontrol = reset ? alucontrol : '0;
endmodule

// File: tb/tb_multicycle_controller.sv
// tb_multicycle_controller: randomized instruction stream checked against a per-instruction cycle model.
module tb_multicycle_controller;
`ifdef MC_MEM_WAIT_EN
  localparam bit WAIT_EN = 1'b1;
`else
  localparam bit WAIT_EN = 1'b0;
`endif
  typedef enum {P_F, P_D, P_MA, P_MR, P_MWB, P_MW, P_EX, P_AWB, P_BR, P_IX, P_IWB, P_J} phase_t;
  typedef phase_t pq_t[$];
  logic clk = 1'b0;
  logic reset = 1'b0;
  int n_cmp = 0;
  int n_bad = 0;
  logic [16:0] act;
  multicycle_controller_if bus ();
  multicycle_controller dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;
  assign act = {bus.pcen, bus.memwrite, bus.irwrite, bus.regwrite, bus.alusrca, bus.alusrcb, bus.pcsrc,
                bus.iord, bus.memtoreg, bus.regdst, bus.zeroext, bus.alucontrol, bus.illegal};
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  function automatic bit legal(input logic [5:0] o);
    return o inside {6'h00, 6'h02, 6'h04, 6'h05, 6'h08, 6'h0C, 6'h0D, 6'h23, 6'h2B};
  endfunction
  // Cycle-by-cycle life of one instruction; its length is the CPI.
  function automatic pq_t seq_of(input logic [5:0] o);
    case (o)
      6'h23:               return {P_F, P_D, P_MA, P_MR, P_MWB};
      6'h2B:               return {P_F, P_D, P_MA, P_MW};
      6'h00:               return {P_F, P_D, P_EX, P_AWB};
      6'h04, 6'h05:        return {P_F, P_D, P_BR};
      6'h08, 6'h0C, 6'h0D: return {P_F, P_D, P_IX, P_IWB};
      6'h02:               return {P_F, P_D, P_J};
      default:             return {P_F, P_D};
    endcase
  endfunction
  function automatic logic [16:0] expv(input phase_t p, input logic [5:0] o, input logic [5:0] f,
                                       input logic z, input logic r);
    logic pcen = 0, mw = 0, irw = 0, rw = 0, asa = 0, iord = 0, m2r = 0, rd = 0, zx = 0, ill = 0;
    logic [1:0] asb = 2'b00, ps = 2'b00;
    logic [2:0] ac = 3'b010;
    logic go;
    go = !WAIT_EN || r;
    case (p)
      P_F:   begin irw = go; pcen = go; asb = 2'b01; end
      P_D:   begin asb = 2'b11; ill = !legal(o); end
      P_MA:  begin asa = 1; asb = 2'b10; end
      P_MR:  iord = 1;
      P_MWB: begin m2r = 1; rw = 1; end
      P_MW:  begin iord = 1; mw = go; end
      P_EX:  begin
        asa = 1;
        ac = f == 6'h22 ? 3'b110 : f == 6'h24 ? 3'b000 : f == 6'h25 ? 3'b001 : f == 6'h2A ? 3'b111 : 3'b010;
      end
      P_AWB: begin rd = 1; rw = 1; end
      P_BR:  begin asa = 1; ac = 3'b110; ps = 2'b01; pcen = (o == 6'h04) ? z : !z; end
      P_IX:  begin
        asa = 1; asb = 2'b10; zx = o inside {6'h0C, 6'h0D};
        ac = o == 6'h0C ? 3'b000 : o == 6'h0D ? 3'b001 : 3'b010;
      end
      P_IWB: rw = 1;
      P_J:   begin ps = 2'b10; pcen = 1; end
      default: ;
    endcase
    return {pcen, mw, irw, rw, asa, asb, ps, iord, m2r, rd, zx, ac, ill};
  endfunction
  // zm: 0/1 forces the zero flag, anything else randomizes it every cycle.
  task automatic run_instr(input logic [5:0] o, input logic [5:0] f, input int zm);
    pq_t seq;
    int i;
    bit stall;
    seq = seq_of(o);
    i = 0;
    bus.op = o;
    bus.funct = f;
    for (int cyc = 0; cyc < 40 && i < seq.size(); cyc++) begin
      bus.zero = (zm == 0 || zm == 1) ? zm[0] : 1'($urandom);
      bus.mem_ready = WAIT_EN ? ($urandom_range(0, 3) != 0) : 1'($urandom);
      #1;
      check($sformatf("%s op=%h funct=%h", seq[i].name(), o, f), act,
            expv(seq[i], o, f, bus.zero, bus.mem_ready));
      stall = WAIT_EN && !bus.mem_ready && (seq[i] inside {P_F, P_MR, P_MW});
      @(posedge clk);
      #1;
      if (!stall) i++;
    end
    if (i < seq.size()) check("timeout", i, seq.size());
  endtask
  logic [5:0] ops[9] = '{6'h23, 6'h2B, 6'h00, 6'h04, 6'h05, 6'h08, 6'h0C, 6'h0D, 6'h02};
  logic [5:0] fns[5] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A};
  initial begin
    logic [5:0] o, f;
    bus.op = 6'h23;
    bus.funct = 6'h2A;
    bus.zero = 1'b1;
    bus.mem_ready = 1'b1;
    repeat (3) begin
      @(posedge clk);
      #1;
      check("reset outputs", act, 17'h0);
    end
    reset = 1'b1;
    run_instr(6'h23, 6'h20, -1);
    run_instr(6'h04, 6'h20, 1);
    run_instr(6'h05, 6'h20, 1);
    run_instr(6'h05, 6'h20, 0);
    run_instr(6'h00, 6'h2A, -1);
    run_instr(6'h0D, 6'h00, -1);
    run_instr(6'h3F, 6'h00, -1);
    run_instr(6'h02, 6'h00, -1);
    bus.op = 6'h2B;
    bus.mem_ready = 1'b1;
    repeat (3) begin
      @(posedge clk);
      #1;
    end
`ifdef MC_MEM_WAIT_EN
    bus.mem_ready = 1'b0;
    repeat (3) begin
      #1;
      check("memwrite while waiting", bus.memwrite, 1'b0);
      @(posedge clk);
      #1;
    end
    bus.mem_ready = 1'b1;
`endif
    #1;
    check("memwrite in MEMWR", bus.memwrite, 1'b1);
    reset = 1'b0;
    #1;
    check("memwrite after abort", bus.memwrite, 1'b0);
    check("outputs after abort", act, 17'h0);
    @(posedge clk);
    #1;
    reset = 1'b1;
    for (int k = 0; k < 200; k++) begin
      int idx;
      idx = $urandom_range(0, 9);
      o = (idx < 9) ? ops[idx] : 6'($urandom_range(0, 63));
      if (!legal(o) && idx < 9) o = 6'h3F;
      idx = $urandom_range(0, 5);
      f = (idx < 5) ? fns[idx] : 6'($urandom_range(0, 63));
      run_instr(o, f, -1);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
